// File: rtl/uart_rx_capture.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_capture
// Purpose  : 8N1 UART receiver feeding a byte FIFO with a valid/ready output.
//            It reports framing errors, parity errors and FIFO overruns as
//            one-cycle pulses, and keeps a saturating dropped-byte counter.
// Macro    : UART_RX_PARITY_EN - when defined, frames are 8E1 and an even
//            parity bit is checked after data bit 7.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_capture #(
    parameter int CLOCKS_PER_BIT = 16,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun,
    output logic [7:0] overrun_count,
    output logic       busy
);

    localparam int c_CNT_W = $clog2(CLOCKS_PER_BIT);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH) + 1;
    localparam int c_IDX_W = c_PTR_W - 1;

    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    logic               rx_meta_q, rx_meta_d;
    logic               rx_s_q,    rx_s_d;
    state_t             state_q,   state_d;
    logic [c_CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q,   shift_d;
    logic               frame_err_q,  frame_err_d;
    logic               parity_err_q, parity_err_d;
    logic               overrun_q,    overrun_d;
    logic [7:0]         ovr_cnt_q,    ovr_cnt_d;
    logic [c_PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [7:0]         last_q,    last_d;
    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [7:0]         mem_d [FIFO_DEPTH];
`ifdef UART_RX_PARITY_EN
    logic               par_bad_q, par_bad_d;
`endif

    logic               w_tick;
    logic               w_push;
    logic               w_byte_ok;
    logic               w_empty;
    logic               w_full;
    logic               w_pop;
    logic               w_wr_en;
    logic [c_IDX_W-1:0] w_wr_idx;
    logic [c_IDX_W-1:0] w_rd_idx;

    assign w_tick = (cnt_q == '0);

`ifdef UART_RX_PARITY_EN
    assign w_byte_ok = ~par_bad_q;
`else
    assign w_byte_ok = 1'b1;
`endif

    // Receive FSM: synchroniser, bit timing, shift register and error pulses
    always_comb begin
        rx_meta_d    = rx;
        rx_s_d       = rx_meta_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        frame_err_d  = 1'b0;
        parity_err_d = 1'b0;
        w_push       = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d = S_START;
                    cnt_d   = c_CNT_HALF;
                end
            end
            S_START: begin
                if (!w_tick) begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end else if (rx_s_q) begin
                    // Start bit did not survive to mid-bit: treat as a glitch.
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    cnt_d     = c_CNT_FULL;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                end
            end
            S_DATA: begin
                if (!w_tick) begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end else begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = c_CNT_FULL;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (!w_tick) begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end else begin
                    // Even parity: data bits plus parity bit must XOR to zero.
                    par_bad_d    = ^{shift_q, rx_s_q};
                    parity_err_d = ^{shift_q, rx_s_q};
                    state_d      = S_STOP;
                    cnt_d        = c_CNT_FULL;
                end
            end
`endif
            S_STOP: begin
                if (!w_tick) begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end else if (rx_s_q) begin
                    w_push  = w_byte_ok;
                    state_d = S_IDLE;
                end else begin
                    frame_err_d = 1'b1;
                    state_d     = S_BREAK;
                end
            end
            S_BREAK: begin
                // Hold here until the line returns high so a stuck-low line
                // reports only one framing error.
                if (rx_s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign w_wr_idx = wr_ptr_q[c_IDX_W-1:0];
    assign w_rd_idx = rd_ptr_q[c_IDX_W-1:0];
    assign w_empty  = (wr_ptr_q == rd_ptr_q);
    assign w_full   = (wr_ptr_q[c_PTR_W-1] != rd_ptr_q[c_PTR_W-1]) &&
                      (w_wr_idx == w_rd_idx);
    assign w_pop    = ~w_empty & out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign w_wr_en  = w_push & (~w_full | w_pop);

    // FIFO storage, pointers, last-popped byte and overrun accounting
    always_comb begin
        mem_d = mem_q;
        if (w_wr_en) begin
            mem_d[w_wr_idx] = shift_q;
        end
        wr_ptr_d  = w_wr_en ? (wr_ptr_q + c_PTR_ONE) : wr_ptr_q;
        rd_ptr_d  = w_pop   ? (rd_ptr_q + c_PTR_ONE) : rd_ptr_q;
        last_d    = w_pop   ? mem_q[w_rd_idx] : last_q;
        overrun_d = w_push & w_full & ~w_pop;
        ovr_cnt_d = ovr_cnt_q;
        if (overrun_d && (ovr_cnt_q != 8'hFF)) begin
            ovr_cnt_d = ovr_cnt_q + 8'd1;
        end
    end

    // Control and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'h00;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            ovr_cnt_q    <= 8'h00;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            last_q       <= 8'h00;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            overrun_q    <= overrun_d;
            ovr_cnt_q    <= ovr_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            last_q       <= last_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
`endif
        end
    end

    // FIFO data array; contents are only observable through valid pointers
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign out_valid     = ~w_empty;
    assign out_data      = w_empty ? last_q : mem_q[w_rd_idx];
    assign frame_err     = frame_err_q;
    assign parity_err    = parity_err_q;
    assign overrun       = overrun_q;
    assign overrun_count = ovr_cnt_q;
    assign busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_capture
// Purpose  : Self-checking bench for uart_rx_capture. Frames are generated at
//            bit level; a queue-based model predicts delivered bytes, error
//            pulses and overruns, and a monitor pops the queue on each
//            accepted output byte. Honours UART_RX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_capture;

    localparam int c_CPB   = 16;
    localparam int c_DEPTH = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit c_PAR = 1'b1;
`else
    localparam bit c_PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic [7:0] overrun_count;
    logic       busy;

    uart_rx_capture #(
        .CLOCKS_PER_BIT (c_CPB),
        .FIFO_DEPTH     (c_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .frame_err     (frame_err),
        .parity_err    (parity_err),
        .overrun       (overrun),
        .overrun_count (overrun_count),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
    int exp_fe = 0, exp_ov = 0, exp_pe = 0, exp_ovc = 0;
    int ready_mode = 1;   // 0: stalled, 1: always ready, 2: random

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Consumer ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: counts pulses and checks every accepted byte against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (frame_err)  fe_cnt++;
                if (overrun)    ov_cnt++;
                if (parity_err) pe_cnt++;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_byte: got 0x%0h, expected none", out_data);
                    end else begin
                        chk("out_data", int'(out_data), int'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(c_CPB);
    endtask

    // Model: a good byte enters the FIFO unless the stalled FIFO is full
    task automatic model_frame(input logic [7:0] b, input logic stop, input bit pflip);
        if (!stop) exp_fe++;
        if (pflip) exp_pe++;
        if (stop && !pflip) begin
            if (ready_mode == 0 && exp_q.size() >= c_DEPTH) begin
                exp_ov++;
                if (exp_ovc < 255) exp_ovc++;
            end else begin
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input bit pflip, input int low_extra);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (c_PAR) drive_bit((^b) ^ pflip);
        model_frame(b, stop, pflip);
        drive_bit(stop);
        if (!stop) begin
            rx = 1'b0;
            tick(low_extra);
            drive_bit(1'b1);
        end
    endtask

    task automatic checkpoint(input string tag);
        tick(6);
        if (ready_mode != 0) begin
            for (int k = 0; k < 2000 && exp_q.size() != 0; k++) tick(1);
            chk({tag, "_drain"}, exp_q.size(), 0);
        end
        chk({tag, "_frame_err"},  fe_cnt, exp_fe);
        chk({tag, "_overrun"},    ov_cnt, exp_ov);
        chk({tag, "_parity_err"}, pe_cnt, exp_pe);
        chk({tag, "_ovr_count"},  int'(overrun_count), exp_ovc);
        chk({tag, "_busy"},       int'(busy), 0);
    endtask

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        tick(4);
        chk("rst_out_data",   int'(out_data), 0);
        chk("rst_out_valid",  int'(out_valid), 0);
        chk("rst_busy",       int'(busy), 0);
        chk("rst_ovr_count",  int'(overrun_count), 0);
        chk("rst_pulses",     int'({frame_err, parity_err, overrun}), 0);
        rst = 1'b0;
        tick(5);

        // Back-to-back frames
        send_frame(8'h55, 1'b1, 1'b0, 0);
        send_frame(8'hA3, 1'b1, 1'b0, 0);
        checkpoint("b2b");
        chk("hold_last_popped", int'(out_data), 8'hA3);

        // Short low glitch must be rejected
        rx = 1'b0;
        tick(6);
        rx = 1'b1;
        tick(30);
        checkpoint("glitch");

        // Framing error with line stuck low
        send_frame(8'h41, 1'b0, 1'b0, 24);
        checkpoint("frame");

        // Overrun with stalled consumer
        ready_mode = 0;
        tick(2);
        for (int i = 0; i < 10; i++) send_frame(8'(i), 1'b1, 1'b0, 0);
        checkpoint("stall");
        chk("stall_out_valid", int'(out_valid), 1);
        chk("stall_head", int'(out_data), 0);
        ready_mode = 1;
        checkpoint("drain");

        // Reset during bit 4 of 0x7E
        begin
            logic [7:0] b;
            b = 8'h7E;
            drive_bit(1'b0);
            for (int i = 0; i < 4; i++) drive_bit(b[i]);
            rx = b[4];
            tick(c_CPB / 2);
        end
        rst = 1'b1;
        exp_ovc = 0;
        tick(3);
        rst = 1'b0;
        rx  = 1'b1;
        tick(20);
        chk("midrst_busy",      int'(busy), 0);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_ovr_count", int'(overrun_count), 0);
        send_frame(8'h12, 1'b1, 1'b0, 0);
        checkpoint("midrst");

        if (c_PAR) begin
            send_frame(8'h03, 1'b1, 1'b1, 0);
            checkpoint("par_bad");
            send_frame(8'h03, 1'b1, 1'b0, 0);
            checkpoint("par_good");
        end

        // Randomised traffic with a random consumer
        ready_mode = 2;
        for (int f = 0; f < 24; f++) begin
            logic [7:0] b;
            logic       stop;
            bit         pflip;
            b     = 8'($urandom_range(0, 255));
            stop  = ($urandom_range(0, 5) != 0);
            pflip = c_PAR && ($urandom_range(0, 5) == 0);
            send_frame(b, stop, pflip, $urandom_range(0, 30));
            rx = 1'b1;
            tick($urandom_range(0, 20));
        end
        ready_mode = 1;
        checkpoint("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
